// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = op_a - op_b - b_in, one bit per cycle
// through a single borrow flip-flop, with a start/busy/done handshake.
module serial_ripple_subtractor #(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] op_a,
  input  logic [BIT_WIDTH-1:0] op_b,
  input  logic                 b_in,
  output logic                 busy,
  output logic                 done,
  output logic [BIT_WIDTH-1:0] diff,
  output logic                 b_out
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one operand bit processed per cycle, LSB first
  // FIN   | result presented, done pulses; start here is accepted back-to-back
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam int CW = $clog2(BIT_WIDTH) + 1;

  state_t               state, state_nxt;
  logic [BIT_WIDTH-1:0] sh_a, sh_b, res;
  logic                 br;
  logic [CW-1:0]        cnt;

  logic a0, b0, d_bit, br_nxt, last_bit, accept;

  always_comb begin
    a0       = sh_a[0];
    b0       = sh_b[0];
    d_bit    = a0 ^ b0 ^ br;
    br_nxt   = (~a0 & b0) | (~(a0 ^ b0) & br);
    last_bit = (cnt == CW'(BIT_WIDTH - 1));
    accept   = start && (state != RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are loaded on the last RUN edge so they are already valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a  <= '0;
      sh_b  <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      b_out <= 1'b0;
    end else if (accept) begin
      sh_a <= op_a;
      sh_b <= op_b;
      br   <= b_in;
      res  <= '0;
      cnt  <= '0;
    end else if (state == RUN) begin
      sh_a <= {1'b0, sh_a[BIT_WIDTH-1:1]};
      sh_b <= {1'b0, sh_b[BIT_WIDTH-1:1]};
      res  <= {d_bit, res[BIT_WIDTH-1:1]};
      br   <= br_nxt;
      cnt  <= cnt + CW'(1);
      if (last_bit) begin
        diff  <= {d_bit, res[BIT_WIDTH-1:1]};
        b_out <= br_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor at BIT_WIDTH 16 (directed + random)
// and BIT_WIDTH 4 (exhaustive), against a plain-arithmetic reference.
module tb_serial_ripple_subtractor;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, b_in, busy, done, b_out;
  logic [15:0] op_a, op_b, diff;

  logic        start4, b_in4, busy4, done4, b_out4;
  logic [3:0]  op_a4, op_b4, diff4;

  serial_ripple_subtractor #(.BIT_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .b_in(b_in),
    .busy(busy), .done(done), .diff(diff), .b_out(b_out)
  );

  serial_ripple_subtractor #(.BIT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op_a(op_a4), .op_b(op_b4), .b_in(b_in4),
    .busy(busy4), .done(done4), .diff(diff4), .b_out(b_out4)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] prev16 = '0;
  logic [3:0]  prev4  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model16(input logic [15:0] a, input logic [15:0] b, input logic bi);
    return {1'b0, a} - {1'b0, b} - 17'(bi);
  endfunction

  function automatic logic [4:0] model4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    return {1'b0, a} - {1'b0, b} - 5'(bi);
  endfunction

  // Issues a start at the current negedge and returns at the negedge of the done cycle.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bi);
    logic [16:0] r;
    int cyc, busy_n;
    r    = model16(a, b, bi);
    op_a = a; op_b = b; b_in = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_a = 16'($urandom); op_b = 16'($urandom); b_in = 1'($urandom_range(0, 1));
    check("busy_cycle1", busy, 1);
    check("done_cycle1", done, 0);
    check("diff_held", diff, prev16);
    cyc = 1; busy_n = 0;
    while (done !== 1'b1 && cyc < 60) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      cyc++;
    end
    check("latency16", cyc, 17);
    check("busy_count16", busy_n, 16);
    check("busy_at_done", busy, 0);
    check("diff16", diff, r[15:0]);
    check("b_out16", b_out, r[16]);
    prev16 = r[15:0];
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    logic [4:0] r;
    int cyc, busy_n;
    r     = model4(a, b, bi);
    op_a4 = a; op_b4 = b; b_in4 = bi; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; op_a4 = 4'($urandom); op_b4 = 4'($urandom);
    check("busy4_cycle1", busy4, 1);
    check("diff4_held", diff4, prev4);
    cyc = 1; busy_n = 0;
    while (done4 !== 1'b1 && cyc < 30) begin
      if (busy4 === 1'b1) busy_n++;
      @(negedge clk);
      cyc++;
    end
    check("latency4", cyc, 5);
    check("busy_count4", busy_n, 4);
    check("diff4", diff4, r[3:0]);
    check("b_out4", b_out4, r[4]);
    prev4 = r[3:0];
  endtask

  initial begin
    int cyc, n_done;
    logic [16:0] r;

    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; b_in = 1'b0;
    start4 = 1'b0; op_a4 = '0; op_b4 = '0; b_in4 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_b_out", b_out, 0);
    check("rst_busy4", busy4, 0);
    check("rst_diff4", diff4, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases, issued back-to-back through FIN.
    op16(16'd27, 16'd15, 1'b0);
    op16(16'd12, 16'd15, 1'b1);
    op16(16'd0, 16'd0, 1'b1);
    op16(16'd65535, 16'd65535, 1'b0);
    op16(16'd65534, 16'd65535, 1'b1);
    op16(16'd65535, 16'd0, 1'b0);
    @(negedge clk);
    check("idle_after_fin", busy, 0);
    check("done_single", done, 0);

    // start while busy is ignored; held start is accepted in FIN.
    op_a = 16'd27; op_b = 16'd15; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (cyc < 5) begin @(negedge clk); cyc++; end
    op_a = 16'd100; op_b = 16'd1; b_in = 1'b0; start = 1'b1;
    while (done !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
    r = model16(16'd27, 16'd15, 1'b0);
    check("busy_start_latency", cyc, 17);
    check("busy_start_diff", diff, r[15:0]);
    @(negedge clk);
    cyc++;
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_done_low", done, 0);
    while (done !== 1'b1 && cyc < 80) begin @(negedge clk); cyc++; end
    r = model16(16'd100, 16'd1, 1'b0);
    check("b2b_latency", cyc, 34);
    check("b2b_diff", diff, r[15:0]);
    prev16 = r[15:0];
    @(negedge clk);

    // Reset mid-operation abandons the transaction.
    op_a = 16'd500; op_b = 16'd200; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (cyc < 8) begin @(negedge clk); cyc++; end
    check("pre_rst_diff", diff, prev16);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_diff", diff, 0);
    check("mid_rst_b_out", b_out, 0);
    n_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check("no_done_after_rst", n_done, 0);
    prev16 = '0;
    op16(16'd500, 16'd200, 1'b0);
    @(negedge clk);

    // start and rst together: rst wins.
    op_a = 16'd9; op_b = 16'd3; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check("rst_start_busy", busy, 0);
    @(negedge clk);
    check("rst_start_busy2", busy, 0);
    check("rst_start_done", done, 0);
    prev16 = '0;

    // Randomized back-to-back transactions.
    for (int i = 0; i < 1000; i++)
      op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    @(negedge clk);

    // Exhaustive 4-bit instance.
    prev4 = '0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int bi = 0; bi < 2; bi++)
          op4(4'(a), 4'(b), 1'(bi));
    @(negedge clk);
    check("idle4_end", busy4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
